pattern_stream_sequencer: RTL

// - Read-side pacer for the 32-bit pattern FIFO that feeds the MSTREAM ODDR outputs.
// - Generates stream_en, which drives the FIFO rd_en and the 1-cycle-delayed sensor enable.
// - Emits exactly ROWS words per pattern as a contiguous burst, then idles GAP cycles.
// - Repeats for num_pat patterns, then reports done.
// - Does not start a burst until the FIFO holds a full pattern, so bursts are never torn.

---
 rtl/pattern_stream_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pattern_stream_sequencer.sv
// Read-side pacer for the pattern FIFO: emits full-pattern bursts of stream_en separated by gaps.
// A burst starts only once the FIFO holds a complete pattern, so bursts are never torn.
module pattern_stream_sequencer #(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      num_pat,
    input  logic [CNT_W-1:0] rows_per_pat,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic [CNT_W-1:0] fifo_rd_count,
    input  logic             fifo_empty,
    output logic             stream_en,
    output logic             pat_start,
    output logic [31:0]      pat_cnt,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_STREAM,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [31:0]      r_num_lat;
    logic [CNT_W-1:0] r_rows_lat;
    logic [GAP_W-1:0] r_gap_lat;
    logic [CNT_W-1:0] r_row;
    logic [GAP_W-1:0] r_gap;
    logic [31:0]      r_pat_cnt;
    logic             r_underrun;
    logic             r_stream_en;
    logic             r_pat_start;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last_row;
    logic             w_last_pat;
    logic             w_gap_end;

    assign w_accept   = (r_state == S_IDLE) && start && !abort;
    assign w_last_row = (r_row == (r_rows_lat - CNT_W'(1)));
    assign w_last_pat = ((r_pat_cnt + 32'd1) == r_num_lat);
    assign w_gap_end  = (r_gap == (r_gap_lat - GAP_W'(1)));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((num_pat == '0) || (rows_per_pat == '0))
                        w_next = S_DONE;
                    else
                        w_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (fifo_rd_count >= r_rows_lat)
                    w_next = S_STREAM;
            end
            S_STREAM: begin
                if (w_last_row) begin
                    if (w_last_pat)
                        w_next = S_DONE;
                    else if (r_gap_lat == '0)
                        w_next = S_WAIT_DATA;
                    else
                        w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end)
                    w_next = S_WAIT_DATA;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (abort)
            w_next = S_IDLE;
    end

    // Outputs are registered from the next state so they carry no combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_stream_en <= 1'b0;
            r_pat_start <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_stream_en <= (w_next == S_STREAM);
            r_pat_start <= (w_next == S_STREAM) && (r_state != S_STREAM);
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_lat  <= '0;
            r_rows_lat <= '0;
            r_gap_lat  <= '0;
        end else if (w_accept) begin
            r_num_lat  <= num_pat;
            r_rows_lat <= rows_per_pat;
            r_gap_lat  <= gap_cycles;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row <= '0;
            r_gap <= '0;
        end else begin
            if ((r_state == S_STREAM) && (w_next == S_STREAM))
                r_row <= r_row + CNT_W'(1);
            else
                r_row <= '0;
            if ((r_state == S_GAP) && (w_next == S_GAP))
                r_gap <= r_gap + GAP_W'(1);
            else
                r_gap <= '0;
        end
    end

    // Abort freezes pat_cnt, so an abort on the last row does not count that pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat_cnt  <= '0;
            r_underrun <= 1'b0;
        end else if (w_accept) begin
            r_pat_cnt  <= '0;
            r_underrun <= 1'b0;
        end else begin
            if ((r_state == S_STREAM) && w_last_row && !abort)
                r_pat_cnt <= r_pat_cnt + 32'd1;
            if (r_stream_en && fifo_empty)
                r_underrun <= 1'b1;
        end
    end

    assign stream_en = r_stream_en;
    assign pat_start = r_pat_start;
    assign pat_cnt   = r_pat_cnt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underrun  = r_underrun;

endmodule
